// File: rtl/cpu_fetch.sv
// Instruction prefetch unit: keeps its own fetch PC, issues halfword reads whenever
// the memory port is granted, and buffers returned instructions for decode.
module cpu_fetch #(
  parameter  int MEM_DEPTH   = 2**12,
  parameter  int QUEUE_DEPTH = 4,
  localparam int ADDR_WIDTH  = $clog2(MEM_DEPTH*2),
  localparam int LVL_W       = $clog2(QUEUE_DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_gnt,
  input  logic [0:1][7:0]       i_mem_do,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_rd_en,
  input  logic                  i_branch,
  input  logic [ADDR_WIDTH-1:0] i_branch_addr,
  output logic [15:0]           o_ir,
  output logic [ADDR_WIDTH-1:0] o_ir_pc,
  output logic                  o_ir_vld,
  input  logic                  i_ir_rdy,
  output logic [LVL_W-1:0]      o_level
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
  logic [15:0]           qdata_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] qpc_q   [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]      count_q, count_d;
  logic                  infl_q, infl_d;
  logic                  kill_q, kill_d;
  logic                  pop, push, issue;
  logic [LVL_W:0]        occupancy;
  logic                  branch_lsb_unused;

  assign branch_lsb_unused = i_branch_addr[0];

  // Slots already promised: queued entries plus the read in flight, less the one leaving now.
  assign pop       = (count_q != '0) & i_ir_rdy;
  assign occupancy = {1'b0, count_q} + (LVL_W+1)'(infl_q) - (LVL_W+1)'(pop);
  assign issue     = rst & i_mem_gnt & ~i_branch & (occupancy < (LVL_W+1)'(QUEUE_DEPTH));
  assign push      = infl_q & ~kill_q & ~i_branch;

  always_comb begin
    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    infl_d   = issue;
    kill_d   = 1'b0;
    if (i_branch) begin
      fpc_d    = {i_branch_addr[ADDR_WIDTH-1:1], 1'b0};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      kill_d   = infl_q;
    end else begin
      if (issue) fpc_d = fpc_q + ADDR_WIDTH'(2);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      infl_q   <= 1'b0;
      kill_q   <= 1'b0;
    end else begin
      fpc_q    <= fpc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      infl_q   <= infl_d;
      kill_q   <= kill_d;
    end
  end

  // fpc has already advanced past the outstanding read, so its address is fpc - 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        qdata_q[i] <= '0;
        qpc_q[i]   <= '0;
      end
    end else if (push) begin
      qdata_q[wr_ptr_q] <= {i_mem_do[0], i_mem_do[1]};
      qpc_q[wr_ptr_q]   <= fpc_q - ADDR_WIDTH'(2);
    end
  end

  assign o_mem_addr  = fpc_q;
  assign o_mem_rd_en = issue;
  assign o_mem_en    = issue;
  assign o_ir        = qdata_q[rd_ptr_q];
  assign o_ir_pc     = qpc_q[rd_ptr_q];
  assign o_ir_vld    = (count_q != '0);
  assign o_level     = count_q;

endmodule

// File: doc/cpu_fetch.md
# cpu_fetch

Parametrised instruction prefetch unit for the next-generation core, replacing the fetch path where the PC drives the memory address directly and every instruction costs a full fetch round trip. It keeps its own fetch PC and issues halfword reads to the instruction memory port whenever the arbiter grants the port. Returned halfwords go into a QUEUE_DEPTH-entry queue, tagged with their byte address. Decode pops entries with a valid/ready handshake, and a taken branch flushes the queue and redirects fetch.

## Interface
- MEM_DEPTH, 2**12 — memory size in halfwords; ADDR_WIDTH = $clog2(MEM_DEPTH*2) (byte address, localparam)
- QUEUE_DEPTH, 4 — prefetch queue entries; power of two, ≥ 2

- clk  in  1  — single clock, all state on rising edge
- rst  in  1  — reset, asynchronous, active-low
- i_mem_gnt  in  1  — port granted to fetch this cycle (data accesses have priority)
- i_mem_do  in  [0:1][7:0]  — read data, valid the cycle after o_mem_rd_en
- o_mem_addr  out  ADDR_WIDTH  — byte address of the halfword being fetched (equals fetch PC)
- o_mem_en  out  1  — memory enable, equal to o_mem_rd_en
- o_mem_rd_en  out  1  — read issued this cycle
- i_branch  in  1  — redirect fetch (single-cycle pulse)
- i_branch_addr  in  ADDR_WIDTH  — redirect target; bit 0 ignored
- o_ir  out  16  — head-of-queue instruction ({byte0, byte1})
- o_ir_pc  out  ADDR_WIDTH  — byte address of o_ir
- o_ir_vld  out  1  — queue non-empty
- i_ir_rdy  in  1  — consumer accepts head; pop when o_ir_vld & i_ir_rdy
- o_level  out  $clog2(QUEUE_DEPTH+1)  — current queue occupancy

## Operation
- State:
  - fetch PC fpc (bit 0 always 0)
  - queue storage, read pointer, write pointer and count
  - in-flight flag infl (one read outstanding)
  - kill flag
- Issue condition: issue = i_mem_gnt & ~i_branch & (count + infl − pop < QUEUE_DEPTH). On issue, fpc += 2, wrapping modulo 2**ADDR_WIDTH.
- Response: the cycle after an issue, infl = 1. The halfword on i_mem_do is pushed together with its address unless kill is set.
- Pop: when o_ir_vld & i_ir_rdy, advance the read pointer. Push and pop in the same cycle leave count unchanged; this is legal when full and when count = 1.
- Branch (i_branch = 1):
  - queue emptied (count, pointers reset)
  - fpc <= {i_branch_addr[ADDR_WIDTH-1:1], 1'b0}
  - no issue in that cycle
  - kill <= infl, so a response arriving next cycle is dropped
  - a pop in the same cycle is still counted as consumed
  - branch overrides the push of a returning response in the same cycle
- Pointers wrap modulo QUEUE_DEPTH. The count distinguishes full from empty.
- No grant: no issue, fpc holds, and the queue drains normally.

## Timing
- Reset (rst low, asynchronous):
  - fpc = 0, count = 0, infl = 0, kill = 0
  - o_mem_en = 0, o_mem_rd_en = 0, o_mem_addr = 0
  - o_ir_vld = 0, o_ir = 0, o_ir_pc = 0, o_level = 0
- Reset mid-operation aborts any in-flight read; its response is never pushed.
- Memory read latency is 1 cycle. Issue in cycle N → data on i_mem_do in N+1 → pushed at the end of N+1 → o_ir_vld in N+2.
- Branch in cycle T with grant held: first issue at the target in T+1, o_ir_vld with o_ir_pc = target in T+3.
- Steady state with continuous grant and i_ir_rdy = 1: one instruction per cycle for any QUEUE_DEPTH ≥ 2.
- o_mem_addr, o_mem_en and o_mem_rd_en are combinational from state, i_mem_gnt and i_branch. o_ir, o_ir_pc and o_ir_vld are driven from registers only.

## Test plan
- Reset release, grant always 1, i_ir_rdy = 1, memory holding addr/2 per halfword → o_ir_pc = 0, 2, 4, … back-to-back from cycle 2; o_ir = 0, 1, 2, ….
- i_ir_rdy = 0 for 10 cycles → o_level saturates at QUEUE_DEPTH and issues stop. Then rdy = 1 → no halfword lost or duplicated; addresses contiguous.
- Branch to 0x101 while full, with one read in flight → the in-flight data is dropped. The next o_ir_pc = 0x100 at T+3.
- Grant toggling 1/0 every cycle → fetch continues in order at a rate of one per two cycles.
- fpc at 2**ADDR_WIDTH − 2 → next fetch address wraps to 0.
- Assert rst low in the middle of a read → all outputs 0 immediately. After release, fetch restarts at address 0.
